// File: rtl/mac_tx_fcs_ctrl.sv
// Purpose: TX frame sequencer; forwards framer bytes, zero-pads to MIN_FRAME_LEN, appends Ethernet FCS, enforces IFG.
// Latency: 0 cycles in DATA (combinational pass-through); one IDLE bubble per frame; IFG_CYCLES idle cycles after FCS.
// Backpressure: m_tready gates every byte; PAD/FCS hold m_tvalid/m_tdata until accepted; DATA passes ready upstream.
module mac_tx_fcs_ctrl #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_CYCLES    = 12,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic                 s_tuser,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 crc_clr,
  output logic                 crc_valid,
  output logic [7:0]           crc_data,
  input  logic [31:0]          crc_state,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_len
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  state_t               r_state;
  logic [LEN_WIDTH-1:0] r_byte_cnt;
  logic [LEN_WIDTH-1:0] r_frame_len;
  logic [1:0]           r_fcs_idx;
  logic                 r_bad;
  logic [IFG_W-1:0]     r_ifg_cnt;

  // Unsaturated count+1 decides pad/FCS; the stored counter saturates at all-ones.
  logic [LEN_WIDTH:0]   w_cnt_plus1;
  logic [LEN_WIDTH-1:0] w_cnt_sat;
  logic [LEN_WIDTH+2:0] w_len_plus4;
  logic [LEN_WIDTH-1:0] w_len_sat;
  logic                 w_pad_done;

  assign w_cnt_plus1 = {1'b0, r_byte_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign w_cnt_sat   = w_cnt_plus1[LEN_WIDTH] ? '1 : w_cnt_plus1[LEN_WIDTH-1:0];
  assign w_len_plus4 = {3'b000, r_byte_cnt} + (LEN_WIDTH+3)'(4);
  assign w_len_sat   = (|w_len_plus4[LEN_WIDTH+2:LEN_WIDTH]) ? '1 : w_len_plus4[LEN_WIDTH-1:0];
  assign w_pad_done  = (w_cnt_plus1 >= (LEN_WIDTH+1)'(MIN_FRAME_LEN));
  assign frame_len   = r_frame_len;

  // Handshake and CRC-engine drive decoded from state; DATA must be a zero-latency pass-through.
  always_comb begin
    s_tready   = 1'b0;
    m_tdata    = 8'h00;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    crc_clr    = 1'b0;
    crc_valid  = 1'b0;
    crc_data   = 8'h00;
    frame_done = 1'b0;
    case (r_state)
      ST_IDLE: crc_clr = 1'b1;
      ST_DATA: begin
        m_tdata   = s_tdata;
        m_tvalid  = s_tvalid;
        s_tready  = m_tready;
        crc_data  = s_tdata;
        crc_valid = s_tvalid & m_tready;
      end
      ST_PAD: begin
        m_tvalid  = 1'b1;
        crc_valid = m_tready;
      end
      ST_FCS: begin
        // Engine already holds the final (XORed) CRC: its last update was the previous edge.
        m_tvalid   = 1'b1;
        m_tdata    = crc_state[{r_fcs_idx, 3'b000} +: 8] ^ {8{r_bad}};
        m_tlast    = (r_fcs_idx == 2'd3);
        frame_done = (r_fcs_idx == 2'd3) & m_tready;
      end
      default: crc_clr = 1'b1;
    endcase
  end

  // Frame sequencer: state, byte counter, FCS index, bad flag, IFG timer and frame length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_frame_len <= '0;
      r_fcs_idx   <= 2'd0;
      r_bad       <= 1'b0;
      r_ifg_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_tvalid) begin
            r_state    <= ST_DATA;
            r_byte_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (s_tvalid && m_tready) begin
            r_byte_cnt <= w_cnt_sat;
            if (s_tlast) begin
              r_bad     <= s_tuser;
              r_fcs_idx <= 2'd0;
              r_state   <= w_pad_done ? ST_FCS : ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (m_tready) begin
            r_byte_cnt <= w_cnt_sat;
            if (w_pad_done) begin
              r_fcs_idx <= 2'd0;
              r_state   <= ST_FCS;
            end
          end
        end
        ST_FCS: begin
          if (m_tready) begin
            r_fcs_idx <= r_fcs_idx + 2'd1;
            if (r_fcs_idx == 2'd3) begin
              r_frame_len <= w_len_sat;
              r_ifg_cnt   <= '0;
              r_state     <= (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
            end
          end
        end
        ST_IFG: begin
          if (r_ifg_cnt == IFG_W'(IFG_CYCLES - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_fcs_ctrl.sv
// Purpose: directed bench for mac_tx_fcs_ctrl with behavioural CRC-32 engines attached to two instances.
// Instance A: MIN_FRAME_LEN=0, IFG_CYCLES=0. Instance B: defaults (60, 12).
// Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
module tb_mac_tx_fcs_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sel;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tuser, m_tready;

  logic        s_tready_a, m_tvalid_a, m_tlast_a, crc_clr_a, crc_valid_a, frame_done_a;
  logic [7:0]  m_tdata_a, crc_data_a;
  logic [31:0] crc_state_a, eng_a;
  logic [15:0] frame_len_a;
  logic        s_tready_b, m_tvalid_b, m_tlast_b, crc_clr_b, crc_valid_b, frame_done_b;
  logic [7:0]  m_tdata_b, crc_data_b;
  logic [31:0] crc_state_b, eng_b;
  logic [15:0] frame_len_b;

  mac_tx_fcs_ctrl #(.MIN_FRAME_LEN(0), .IFG_CYCLES(0), .LEN_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid & ~sel), .s_tready(s_tready_a),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(m_tdata_a), .m_tvalid(m_tvalid_a), .m_tready(m_tready),
    .m_tlast(m_tlast_a), .crc_clr(crc_clr_a), .crc_valid(crc_valid_a), .crc_data(crc_data_a),
    .crc_state(crc_state_a), .frame_done(frame_done_a), .frame_len(frame_len_a));

  mac_tx_fcs_ctrl #(.MIN_FRAME_LEN(60), .IFG_CYCLES(12), .LEN_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid & sel), .s_tready(s_tready_b),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready),
    .m_tlast(m_tlast_b), .crc_clr(crc_clr_b), .crc_valid(crc_valid_b), .crc_data(crc_data_b),
    .crc_state(crc_state_b), .frame_done(frame_done_b), .frame_len(frame_len_b));

  // Reflected CRC-32 byte update (poly 0x04C11DB7 reversed = 0xEDB88320).
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] golden(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_upd(c, q[i]);
    return ~c;
  endfunction

  // CRC engines: clear dominates, registered state, output already final-XORed.
  always_ff @(posedge clk) begin
    if (crc_clr_a) eng_a <= 32'hFFFFFFFF;
    else if (crc_valid_a) eng_a <= crc_upd(eng_a, crc_data_a);
  end
  always_ff @(posedge clk) begin
    if (crc_clr_b) eng_b <= 32'hFFFFFFFF;
    else if (crc_valid_b) eng_b <= crc_upd(eng_b, crc_data_b);
  end
  assign crc_state_a = ~eng_a;
  assign crc_state_b = ~eng_b;

  logic        o_s_tready, o_m_tvalid, o_m_tlast, o_crc_clr, o_crc_valid, o_frame_done;
  logic [7:0]  o_m_tdata, o_crc_data;
  logic [15:0] o_frame_len;
  assign o_s_tready   = sel ? s_tready_b   : s_tready_a;
  assign o_m_tvalid   = sel ? m_tvalid_b   : m_tvalid_a;
  assign o_m_tlast    = sel ? m_tlast_b    : m_tlast_a;
  assign o_crc_clr    = sel ? crc_clr_b    : crc_clr_a;
  assign o_crc_valid  = sel ? crc_valid_b  : crc_valid_a;
  assign o_frame_done = sel ? frame_done_b : frame_done_a;
  assign o_m_tdata    = sel ? m_tdata_b    : m_tdata_a;
  assign o_crc_data   = sel ? crc_data_b   : crc_data_a;
  assign o_frame_len  = sel ? frame_len_b  : frame_len_a;

  int n_pass, n_total;
  logic [7:0] tx_q[$], cap_q[$], exp_q[$];
  bit last_q[$], exp_last[$];
  int done_cnt, viol_crc, viol_stab, viol_done, stall_cnt;
  int gap_cnt, gap_final, gap_clr_bad;
  bit acc, tog, prev_stall, in_gap;
  logic [7:0] prev_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: settle, observe the pending handshake, then advance to the next falling edge.
  task automatic cycle();
    logic xfer;
    #1;
    xfer = o_m_tvalid && m_tready;
    acc  = s_tvalid && o_s_tready;
    if (xfer) begin
      cap_q.push_back(o_m_tdata);
      last_q.push_back(o_m_tlast);
    end
    if (o_frame_done) done_cnt++;
    if (o_frame_done !== (xfer && o_m_tlast)) viol_done++;
    if (o_crc_valid && !xfer) viol_crc++;
    if (o_crc_valid && (o_crc_data !== o_m_tdata)) viol_crc++;
    if (prev_stall && (!o_m_tvalid || (o_m_tdata !== prev_dat))) viol_stab++;
    prev_stall = o_m_tvalid && !m_tready;
    prev_dat   = o_m_tdata;
    if (prev_stall) stall_cnt++;
    if (in_gap) begin
      if (acc) begin
        in_gap    = 1'b0;
        gap_final = gap_cnt;
      end else begin
        gap_cnt++;
        if (!o_crc_clr) gap_clr_bad++;
      end
    end
    if (xfer && o_m_tlast) begin
      in_gap      = 1'b1;
      gap_cnt     = 0;
      gap_clr_bad = 0;
    end
    @(negedge clk);
    m_tready = tog ? ~m_tready : 1'b1;
  endtask

  // Offer the first n bytes of tx_q; s_tuser carries junk except on the tlast byte.
  task automatic send(input int n, input bit with_last, input bit user);
    for (int i = 0; i < n; i++) begin
      int w;
      s_tvalid = 1'b1;
      s_tdata  = tx_q[i];
      s_tlast  = with_last && (i == n - 1);
      s_tuser  = (i == n - 1) ? user : ~user;
      w = 0;
      do begin
        cycle();
        w++;
      end while (!acc && w < 200);
      if (!acc) begin
        chk("send_timeout", {31'b0, acc}, 32'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input int n_done);
    int w;
    w = 0;
    while (done_cnt < n_done && w < 400) begin
      cycle();
      w++;
    end
    chk("frame_done_count", done_cnt, n_done);
  endtask

  // Expected wire image of one frame: payload, zero pad, FCS LSB first (inverted when bad).
  task automatic exp_frame(input int n, input int minlen, input bit use_const, input logic [31:0] cval, input bit bad);
    logic [7:0]  f[$];
    logic [31:0] c;
    for (int i = 0; i < n; i++) f.push_back(tx_q[i]);
    while (f.size() < minlen) f.push_back(8'h00);
    c = use_const ? cval : golden(f);
    foreach (f[i]) begin
      exp_q.push_back(f[i]);
      exp_last.push_back(1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(c[8*k +: 8] ^ {8{bad}});
      exp_last.push_back(k == 3);
    end
  endtask

  task automatic clr_cap();
    cap_q.delete();
    last_q.delete();
    exp_q.delete();
    exp_last.delete();
    done_cnt = 0;
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'h0, cap_q[i]}, {24'h0, exp_q[i]});
      chk($sformatf("%s_tlast%0d", tag, i), {31'b0, last_q[i]}, {31'b0, exp_last[i]});
    end
  endtask

  task automatic load_seq(input int n, input logic [7:0] base);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(base + 8'(i));
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    done_cnt = 0; viol_crc = 0; viol_stab = 0; viol_done = 0; stall_cnt = 0;
    gap_cnt = 0; gap_final = -1; gap_clr_bad = 0;
    acc = 0; tog = 0; prev_stall = 0; in_gap = 0; prev_dat = 8'h00;
    rst_n = 1'b0; sel = 1'b0; s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    #1;
    chk("rst_a_s_tready", {31'b0, o_s_tready}, 32'd0);
    chk("rst_a_m_tvalid", {31'b0, o_m_tvalid}, 32'd0);
    chk("rst_a_m_tlast", {31'b0, o_m_tlast}, 32'd0);
    chk("rst_a_crc_clr", {31'b0, o_crc_clr}, 32'd1);
    chk("rst_a_frame_done", {31'b0, o_frame_done}, 32'd0);
    chk("rst_a_frame_len", {16'h0, o_frame_len}, 32'd0);
    sel = 1'b1;
    #1;
    chk("rst_b_crc_clr", {31'b0, o_crc_clr}, 32'd1);
    chk("rst_b_frame_len", {16'h0, o_frame_len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "123456789" through A: FCS 26 39 F4 CB, 13 bytes.
    sel = 1'b0;
    clr_cap();
    load_seq(9, 8'h31);
    exp_frame(9, 0, 1'b1, 32'hCBF43926, 1'b0);
    send(9, 1'b1, 1'b0);
    drain(1);
    cmp("t1");
    chk("t1_frame_len", {16'h0, o_frame_len}, 32'd13);

    // Same frame marked bad: FCS D9 C6 0B 34.
    clr_cap();
    exp_frame(9, 0, 1'b1, 32'hCBF43926, 1'b1);
    send(9, 1'b1, 1'b1);
    drain(1);
    cmp("t2");
    chk("t2_frame_len", {16'h0, o_frame_len}, 32'd13);

    // 1-byte frame through B: padded to 60, 64 transfers.
    sel = 1'b1;
    clr_cap();
    tx_q.delete();
    tx_q.push_back(8'h55);
    exp_frame(1, 60, 1'b0, 32'h0, 1'b0);
    send(1, 1'b1, 1'b0);
    drain(1);
    cmp("t3");
    chk("t3_frame_len", {16'h0, o_frame_len}, 32'd64);

    // Exact-minimum 60-byte frame with m_tready toggling every cycle.
    clr_cap();
    load_seq(60, 8'h00);
    exp_frame(60, 60, 1'b0, 32'h0, 1'b0);
    tog = 1'b1;
    send(60, 1'b1, 1'b0);
    drain(1);
    tog = 1'b0;
    m_tready = 1'b1;
    cmp("t4");
    chk("t4_frame_len", {16'h0, o_frame_len}, 32'd64);
    chk("t4_stalls_seen", {31'b0, (stall_cnt > 0)}, 32'd1);
    chk("t4_stall_stable", viol_stab, 32'd0);
    chk("t4_crc_valid_on_xfer", viol_crc, 32'd0);

    // Back-to-back frames on B: 12 IFG cycles + 1 IDLE bubble before the next accept.
    clr_cap();
    gap_final = -1;
    load_seq(5, 8'hA0);
    exp_frame(5, 60, 1'b0, 32'h0, 1'b0);
    send(5, 1'b1, 1'b0);
    load_seq(3, 8'hC1);
    exp_frame(3, 60, 1'b0, 32'h0, 1'b0);
    send(3, 1'b1, 1'b0);
    drain(2);
    cmp("t5");
    chk("t5_gap_cycles", gap_final, 32'd13);
    chk("t5_gap_crc_clr", gap_clr_bad, 32'd0);
    chk("t5_frame_len", {16'h0, o_frame_len}, 32'd64);

    // Reset after 20 bytes on A aborts silently; next frame is clean.
    sel = 1'b0;
    clr_cap();
    load_seq(30, 8'h10);
    send(20, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", {31'b0, o_m_tvalid}, 32'd0);
    chk("t6_rst_s_tready", {31'b0, o_s_tready}, 32'd0);
    chk("t6_rst_m_tlast", {31'b0, o_m_tlast}, 32'd0);
    chk("t6_rst_crc_clr", {31'b0, o_crc_clr}, 32'd1);
    chk("t6_rst_frame_done", {31'b0, o_frame_done}, 32'd0);
    chk("t6_rst_frame_len", {16'h0, o_frame_len}, 32'd0);
    chk("t6_abort_bytes", cap_q.size(), 32'd20);
    chk("t6_abort_no_tlast", {31'b0, (last_q.sum() with (int'(item)) != 0)}, 32'd0);
    clr_cap();
    load_seq(9, 8'h31);
    exp_frame(9, 0, 1'b1, 32'hCBF43926, 1'b0);
    send(9, 1'b1, 1'b0);
    drain(1);
    cmp("t6");
    chk("t6_frame_len", {16'h0, o_frame_len}, 32'd13);

    chk("frame_done_alignment", viol_done, 32'd0);
    chk("crc_valid_on_xfer_all", viol_crc, 32'd0);
    chk("stall_stable_all", viol_stab, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
